// File: rtl/key_schedule.sv
// SIMON64/96 sequential key expander: streams ROUNDS 32-bit round keys from a
// 96-bit master key under valid/ready flow control, rk0 first.
module key_schedule #(
  parameter int unsigned ROUNDS  = 42,
  parameter logic [61:0] Z_SEQ   = 62'h3369f885192c0ef5,
  parameter logic [31:0] C_CONST = 32'hfffffffc
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [95:0] key_in,
  output logic        busy,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [5:0]  rk_index,
  output logic [31:0] round_key,
  output logic        done
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  state_t      state;
  logic [31:0] w0, w1, w2;
  logic [61:0] zReg;
  logic [31:0] ror3W2, ror4W2, newWord;
  logic        transfer, lastKey;

  assign ror3W2   = {w2[2:0], w2[31:3]};
  assign ror4W2   = {w2[3:0], w2[31:4]};
  // The z bit only ever touches bit 0 of the new word.
  assign newWord  = C_CONST ^ {31'b0, zReg[0]} ^ w0 ^ ror3W2 ^ ror4W2;
  assign transfer = rk_valid && rk_ready;
  assign lastKey  = (rk_index == LAST_IDX);

  // The oldest window word is the key on display, so no separate output register.
  assign round_key = w0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      w0       <= '0;
      w1       <= '0;
      w2       <= '0;
      zReg     <= '0;
      rk_index <= '0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            w0       <= key_in[31:0];
            w1       <= key_in[63:32];
            w2       <= key_in[95:64];
            zReg     <= Z_SEQ;
            rk_index <= '0;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            done     <= (LAST_IDX == 6'd0);
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (transfer) begin
            if (lastKey) begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b0;
              state    <= IDLE;
            end else begin
              w0       <= w1;
              w1       <= w2;
              w2       <= newWord;
              zReg     <= {zReg[0], zReg[61:1]};
              rk_index <= rk_index + 6'd1;
              // done is registered, so it is precomputed for the incoming index.
              done     <= ((rk_index + 6'd1) == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_schedule.sv
// Randomized self-checking bench for key_schedule against an array-based
// SIMON64/96 key schedule reference.
module tb_key_schedule;

  localparam int ROUNDS = 42;
  localparam logic [61:0] ZSEQ = 62'h3369f885192c0ef5;
  localparam logic [31:0] CVAL = 32'hfffffffc;
  localparam logic [95:0] KAT_KEY = 96'h13121110_0b0a0908_03020100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [95:0] key_in;
  logic        busy;
  logic        rk_valid;
  logic        rk_ready;
  logic [5:0]  rk_index;
  logic [31:0] round_key;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [31:0] expKeys [64];
  logic [31:0] kat [5];

  always #5 clk = ~clk;

  key_schedule #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_index(rk_index),
    .round_key(round_key), .done(done)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook schedule: k[i+3] = c ^ z[i mod 62] ^ k[i] ^ S^-3 k[i+2] ^ S^-4 k[i+2].
  task automatic buildKeys(input logic [95:0] key);
    logic [61:0] z;
    z = ZSEQ;
    expKeys[0] = key[31:0];
    expKeys[1] = key[63:32];
    expKeys[2] = key[95:64];
    for (int i = 0; i + 3 < 64; i++)
      expKeys[i + 3] = CVAL ^ 32'(z[i % 62]) ^ expKeys[i]
                     ^ rotr(expKeys[i + 2], 3) ^ rotr(expKeys[i + 2], 4);
  endtask

  task automatic checkIdle(input string tag);
    checkVal({tag, ".valid"}, 64'(rk_valid), 64'd0);
    checkVal({tag, ".busy"}, 64'(busy), 64'd0);
    checkVal({tag, ".done"}, 64'(done), 64'd0);
  endtask

  // Runs one full stream; optionally stalls 5 cycles at stallIdx and pulses a
  // spurious start at ignoreAt. A start is also raised alongside the last transfer.
  task automatic runStream(input logic [95:0] key, input int readyPct,
                           input int stallIdx, input int ignoreAt, input bit isKat);
    int expIdx;
    int stalls;
    int cycles;
    buildKeys(key);
    @(negedge clk);
    key_in = key; start = 1'b1; rk_ready = 1'b0;
    expIdx = 0; stalls = 0; cycles = 0;
    @(negedge clk);
    start = 1'b0;
    while (expIdx < ROUNDS && cycles < 2000) begin
      checkVal("valid", 64'(rk_valid), 64'd1);
      checkVal("busy", 64'(busy), 64'd1);
      checkVal("index", 64'(rk_index), 64'(expIdx));
      checkVal("key", 64'(round_key), 64'(expKeys[expIdx]));
      checkVal("done", 64'(done), 64'(expIdx == ROUNDS - 1));
      if (isKat && expIdx < 5) checkVal("kat", 64'(round_key), 64'(kat[expIdx]));
      key_in = {$urandom, $urandom, $urandom};
      start  = (expIdx == ignoreAt);
      if (expIdx == stallIdx && stalls < 5) begin
        rk_ready = 1'b0;
        stalls++;
      end else begin
        rk_ready = ($urandom_range(99) < readyPct);
      end
      if (rk_ready && expIdx == ROUNDS - 1) start = 1'b1;
      if (rk_ready) expIdx++;
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 2000) checkVal("timeout", 64'd0, 64'd1);
    start = 1'b0; rk_ready = 1'b0;
    checkIdle("end");
    @(negedge clk);
    checkIdle("stillIdle");
  endtask

  initial begin
    int cycles;
    kat[0] = 32'h03020100; kat[1] = 32'h0b0a0908; kat[2] = 32'h13121110;
    kat[3] = 32'hffae9dce; kat[4] = 32'hc4facc91;

    // Reset dominates start.
    rst = 1'b1; start = 1'b1; rk_ready = 1'b0; key_in = KAT_KEY;
    repeat (2) @(negedge clk);
    checkIdle("reset");
    checkVal("reset.key", 64'(round_key), 64'd0);
    checkVal("reset.index", 64'(rk_index), 64'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checkIdle("postReset");

    // Known answer, full-rate consumer.
    runStream(KAT_KEY, 100, -1, -1, 1'b1);
    // Backpressure at rk3, spurious start mid-stream.
    runStream(KAT_KEY, 100, 3, 17, 1'b1);

    // Mid-stream reset at index 10.
    buildKeys(KAT_KEY);
    key_in = KAT_KEY; start = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (!(rk_valid && rk_index == 6'd10) && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    checkVal("midIndex", 64'(rk_index), 64'd10);
    checkVal("midKey", 64'(round_key), 64'(expKeys[10]));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rk_ready = 1'b0;
    checkIdle("midReset");
    checkVal("midReset.key", 64'(round_key), 64'd0);
    checkVal("midReset.index", 64'(rk_index), 64'd0);
    runStream(KAT_KEY, 100, -1, -1, 1'b1);

    // Random keys with random backpressure.
    for (int t = 0; t < 6; t++)
      runStream({$urandom, $urandom, $urandom}, 30 + 10 * t,
                int'($urandom_range(ROUNDS - 1)), int'($urandom_range(ROUNDS - 1)), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/key_schedule.md
Name: key_schedule

Overview:
- Sequential SIMON64/96 key expander: 32-bit words, m = 3 key words, z2 constant sequence.
- Accepts a 96-bit master key and streams ROUNDS round keys, one per accepted beat, under valid/ready flow control.
- Sits between key loading and the SIMON64/96 round datapath, which consumes rk0 first.

Parameters:
- ROUNDS, 42, number of round keys produced per start (legal 4..63).
- Z_SEQ, 62'h3369f885192c0ef5, z2 sequence; bit 0 is used first.
- C_CONST, 32'hfffffffc, round constant c = 2^32 - 4.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin expansion; sampled only when idle.
- key_in  input  96  master key {k2, k1, k0}; k0 = key_in[31:0].
- busy  output  1  high while a round-key stream is in progress.
- rk_valid  output  1  round_key/rk_index are valid.
- rk_ready  input  1  consumer accepts the current round key.
- rk_index  output  6  index of the current round key (0..ROUNDS-1).
- round_key  output  32  current round key.
- done  output  1  high while the last key (index ROUNDS-1) is presented.

Behaviour:
- Reset (synchronous, clk edge with rst=1): busy=0, rk_valid=0, done=0, rk_index=0, round_key=0; window registers and z register cleared. rst dominates start. Reset mid-stream aborts the stream and returns to IDLE.
- States:
  - IDLE: rk_valid=0.
  - STREAM: rk_valid=1.
- IDLE, start=1 at an edge:
  - Load window w0=k0, w1=k1, w2=k2 and z register = Z_SEQ.
  - Set rk_index=0 and go to STREAM.
  - rk_valid and busy are high from the next cycle. Latency is 1 cycle from start to rk0.
- STREAM outputs:
  - round_key = w0 (registered, not combinational from inputs).
  - done = rk_valid && rk_index==ROUNDS-1.
- Handshake: a beat transfers on an edge with rk_valid && rk_ready. Without the handshake, round_key, rk_index and all state hold unchanged, with no limit on stall length.
- On each transfer, when not the last key:
  - new = C_CONST ^ z[0] ^ w0 ^ ror3(w2) ^ ror4(w2). ror4 = ror1 of ror3; bit 0 of the 62-bit z register is XORed into bit 0 only.
  - Shift the window: w0<=w1, w1<=w2, w2<=new.
  - Rotate the z register right by 1 (bit 0 moves to bit 61). It therefore wraps after 62 uses.
  - rk_index increments.
- Key k(i+3) uses z bit i. Keys 0..2 are the raw key words.
- On transfer of index ROUNDS-1: go to IDLE; rk_valid, busy and done fall on the next cycle.
- start asserted while busy is ignored.
- start in the same cycle the last key transfers is also ignored; a new start is accepted once IDLE is visible.
- key_in is sampled only at the accepted start edge; later changes have no effect.
- All arithmetic is pure XOR/rotate on 32 bits, with no carries.

Test Plan:
- Reset: assert rst for 2 cycles with start=1 -> busy=0, rk_valid=0, done=0, round_key=0; no stream begins.
- Known-answer vector:
  - Stimulus: key_in=96'h13121110_0b0a0908_03020100, start pulse, rk_ready=1.
  - Required: rk0=0x03020100, rk1=0x0b0a0908, rk2=0x13121110, rk3=0xffae9dce, rk4=0xc4facc91 on consecutive cycles.
  - Required: exactly 42 valid beats; done only with rk_index=41; busy falls the cycle after.
- Backpressure: same key, hold rk_ready=0 for 5 cycles while rk3 is shown -> round_key stays 0xffae9dce and rk_index stays 3; after release, the next key is 0xc4facc91.
- Ignored start: pulse start with a different key_in while streaming -> sequence unchanged; a start after return to IDLE restarts at rk0 with the new key.
- Mid-stream reset: rst at rk_index=10 -> next cycle all outputs zero and IDLE; a fresh start reproduces rk3=0xffae9dce (z register reloaded).
- Reference model: random keys and random rk_ready, compared against a software SIMON64/96 key schedule for all 42 keys.
